// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, decode constants, FSM state type and op classification
// for the registered ALU-control sequencer.
package alu_ctrl_pkg;

  localparam int unsigned OP_AND    = 0;
  localparam int unsigned OP_OR     = 1;
  localparam int unsigned OP_ADD    = 2;
  localparam int unsigned OP_XOR    = 3;
  localparam int unsigned OP_SLL    = 4;
  localparam int unsigned OP_SRL    = 5;
  localparam int unsigned OP_SUB    = 6;
  localparam int unsigned OP_SRA    = 7;
  localparam int unsigned OP_SLT    = 8;
  localparam int unsigned OP_SLTU   = 9;
  localparam int unsigned OP_MUL    = 10;
  localparam int unsigned OP_MULH   = 11;
  localparam int unsigned OP_MULHSU = 12;
  localparam int unsigned OP_MULHU  = 13;
  localparam int unsigned OP_DIV    = 14;
  localparam int unsigned OP_DIVU   = 16;
  localparam int unsigned OP_REM    = 17;
  localparam int unsigned OP_REMU   = 18;

  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  function automatic logic is_mul(input int unsigned op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(input int unsigned op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUop/funct decode to extended op code; all-ones = invalid.
// M-group decode is present only when RV32M_EN is defined.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [1:0]      ALUop,
  input  logic [6:0]      funct_7,
  input  logic [2:0]      funct_3,
  output logic [OP_W-1:0] operation,
  output logic            invalid
);

  function automatic logic [OP_W-1:0] oc(input int unsigned c);
    return OP_W'(c);
  endfunction

  // funct_3 map shared by R-type (funct_7=0) and I-type
  logic [OP_W-1:0] base_op;
  always_comb begin
    case (funct_3)
      3'b000:  base_op = oc(OP_ADD);
      3'b001:  base_op = oc(OP_SLL);
      3'b010:  base_op = oc(OP_SLT);
      3'b011:  base_op = oc(OP_SLTU);
      3'b100:  base_op = oc(OP_XOR);
      3'b101:  base_op = oc(OP_SRL);
      3'b110:  base_op = oc(OP_OR);
      default: base_op = oc(OP_AND);
    endcase
  end

`ifdef RV32M_EN
  logic [OP_W-1:0] m_op;
  always_comb begin
    case (funct_3)
      3'b000:  m_op = oc(OP_MUL);
      3'b001:  m_op = oc(OP_MULH);
      3'b010:  m_op = oc(OP_MULHSU);
      3'b011:  m_op = oc(OP_MULHU);
      3'b100:  m_op = oc(OP_DIV);
      3'b101:  m_op = oc(OP_DIVU);
      3'b110:  m_op = oc(OP_REM);
      default: m_op = oc(OP_REMU);
    endcase
  end
`endif

  always_comb begin
    operation = '1;
    case (ALUop)
      ALUOP_LS: operation = oc(OP_ADD);
      ALUOP_BR: operation = oc(OP_SUB);
      ALUOP_I:  operation = (funct_3 == 3'b101 && funct_7 == F7_ALT) ? oc(OP_SRA) : base_op;
      default: begin
        if (funct_7 == F7_BASE)                         operation = base_op;
        else if (funct_7 == F7_ALT && funct_3 == 3'b000) operation = oc(OP_SUB);
        else if (funct_7 == F7_ALT && funct_3 == 3'b101) operation = oc(OP_SRA);
`ifdef RV32M_EN
        else if (funct_7 == F7_MEXT)                    operation = m_op;
`endif
      end
    endcase
  end

  assign invalid = &operation;

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU-control decode with multi-cycle M-unit sequencing.
// RV32M_EN enables the MUL/DIV wait states, counter and md_* handshake.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            flush,
  input  logic [1:0]      ALUop,
  input  logic [6:0]      funct_7,
  input  logic [2:0]      funct_3,
  input  logic            md_done,
  output logic [OP_W-1:0] operation,
  output logic            op_valid,
  output logic            illegal,
  output logic            md_start,
  output logic            md_abort,
  output logic            busy
);

  logic [OP_W-1:0] dec_op;
  logic            dec_inv;

  alu_op_decode #(.OP_W(OP_W)) u_dec (
    .ALUop     (ALUop),
    .funct_7   (funct_7),
    .funct_3   (funct_3),
    .operation (dec_op),
    .invalid   (dec_inv)
  );

`ifdef RV32M_EN
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      operation <= '1;
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      md_abort  <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      illegal  <= 1'b0;
      md_start <= 1'b0;
      md_abort <= 1'b0;
      // flush wins over md_done and counter expiry
      if (flush) begin
        md_abort <= (state != IDLE);
        state    <= IDLE;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: if (valid_i) begin
            operation <= dec_op;
            if (is_mul(32'(dec_op))) begin
              state    <= MUL_WAIT;
              cnt      <= CNT_W'(MUL_LAT - 1);
              md_start <= 1'b1;
            end else if (is_div(32'(dec_op))) begin
              state    <= DIV_WAIT;
              md_start <= 1'b1;
            end else begin
              op_valid <= 1'b1;
              illegal  <= dec_inv;
            end
          end
          MUL_WAIT: begin
            if (cnt == '0) begin
              state    <= IDLE;
              op_valid <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DIV_WAIT: if (md_done) begin
            state    <= IDLE;
            op_valid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operation <= '1;
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      illegal  <= 1'b0;
      if (valid_i && !flush) begin
        operation <= dec_op;
        op_valid  <= 1'b1;
        illegal   <= dec_inv;
      end
    end
  end

  assign md_start = 1'b0;
  assign md_abort = 1'b0;
  assign busy     = 1'b0;

  // md_done and MUL_LAT have no function without the M unit
  logic unused_cfg;
  assign unused_cfg = md_done | (MUL_LAT == 0);
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed + random bench for alu_control_seq against a timeline reference model.
// Expectations follow RV32M_EN when the bench is built with it defined.
module tb_alu_control_seq;

  localparam int OP_W    = 5;
  localparam int MUL_LAT = 3;
  localparam int INV     = 31;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  // funct_3 -> op code tables taken straight from the op-code list
  localparam int BASE_T [8] = '{2, 4, 8, 9, 3, 5, 1, 0};
  localparam int MEXT_T [8] = '{10, 11, 12, 13, 14, 16, 17, 18};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0, flush = 1'b0, md_done = 1'b0;
  logic [1:0]      ALUop = '0;
  logic [6:0]      funct_7 = '0;
  logic [2:0]      funct_3 = '0;
  logic [OP_W-1:0] operation;
  logic            op_valid, illegal, md_start, md_abort, busy;

  alu_control_seq #(.OP_W(OP_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush),
    .ALUop(ALUop), .funct_7(funct_7), .funct_3(funct_3), .md_done(md_done),
    .operation(operation), .op_valid(op_valid), .illegal(illegal),
    .md_start(md_start), .md_abort(md_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: busy window tracked as an absolute completion cycle
  int cyc = 0;
  bit m_busy = 0, m_div = 0;
  int m_done = 0;
  int e_op = INV;
  bit e_ov, e_ill, e_st, e_ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_op(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
    case (a)
      2'b00: return 2;
      2'b01: return 6;
      2'b11: return (f3 == 3'd5 && f7 == 7'h20) ? 7 : BASE_T[f3];
      default: begin
        if (f7 == 7'h00) return BASE_T[f3];
        if (f7 == 7'h20) return (f3 == 3'd0) ? 6 : (f3 == 3'd5) ? 7 : INV;
        if (f7 == 7'h01 && M_EN) return MEXT_T[f3];
        return INV;
      end
    endcase
  endfunction

  task automatic step();
    int op;
    e_ov = 0; e_ill = 0; e_st = 0; e_ab = 0;
    if (flush) begin
      e_ab   = m_busy;
      m_busy = 0;
    end else if (!m_busy) begin
      if (valid_i) begin
        op   = ref_op(ALUop, funct_7, funct_3);
        e_op = op;
        if (op >= 10 && op <= 13) begin
          m_busy = 1; m_div = 0; m_done = cyc + MUL_LAT + 1; e_st = 1;
        end else if (op inside {14, 16, 17, 18}) begin
          m_busy = 1; m_div = 1; e_st = 1;
        end else begin
          e_ov = 1; e_ill = (op == INV);
        end
      end
    end else if (m_div ? md_done : (cyc + 1 == m_done)) begin
      m_busy = 0; e_ov = 1;
    end
    cyc++;
    @(posedge clk); #1;
    chk("op_valid",  op_valid,  e_ov);
    chk("illegal",   illegal,   e_ill);
    chk("md_start",  md_start,  e_st);
    chk("md_abort",  md_abort,  e_ab);
    chk("busy",      busy,      m_busy);
    chk("operation", operation, e_op);
  endtask

  task automatic go(input bit v, input logic [1:0] a, input logic [6:0] f7,
                    input logic [2:0] f3, input bit fl = 1'b0, input bit mdd = 1'b0);
    valid_i = v; ALUop = a; funct_7 = f7; funct_3 = f3; flush = fl; md_done = mdd;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; flush = 1'b0; md_done = 1'b0;
    #2;
    m_busy = 0; e_op = INV;
    chk("rst_busy",  busy,      0);
    chk("rst_op",    operation, INV);
    chk("rst_abort", md_abort,  0);
    chk("rst_ov",    op_valid,  0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_op_valid", op_valid, 0);
    chk("reset_illegal",  illegal,  0);
    chk("reset_md_start", md_start, 0);
    chk("reset_md_abort", md_abort, 0);
    chk("reset_busy",     busy,     0);
    chk("reset_op",       operation, INV);
    rst = 1'b0;

    // back-to-back single-cycle ops, including SUB, SRAI, SLTI and an illegal one
    go(1, 2'b10, 7'h20, 3'b000);
    go(1, 2'b00, 7'h00, 3'b010);
    go(1, 2'b01, 7'h00, 3'b000);
    go(1, 2'b11, 7'h20, 3'b101);
    go(1, 2'b11, 7'h00, 3'b010);
    go(1, 2'b10, 7'h02, 3'b101);
    go(0, 2'b00, 7'h00, 3'b000);

    // MUL, then a new op in the completion cycle window
    go(1, 2'b10, 7'h01, 3'b000);
    repeat (3) go(1, 2'b10, 7'h00, 3'b100);
    go(1, 2'b10, 7'h00, 3'b110);
    go(0, 2'b00, 7'h00, 3'b000);

    // DIVU with md_done in N+5, then a stray md_done while idle
    go(1, 2'b10, 7'h01, 3'b101);
    repeat (4) go(0, 2'b00, 7'h00, 3'b000);
    go(0, 2'b00, 7'h00, 3'b000, 1'b0, 1'b1);
    go(0, 2'b00, 7'h00, 3'b000);
    go(0, 2'b00, 7'h00, 3'b000, 1'b0, 1'b1);

    // DIV flushed in N+2, next op accepted right after
    go(1, 2'b10, 7'h01, 3'b100);
    go(0, 2'b00, 7'h00, 3'b000);
    go(0, 2'b00, 7'h00, 3'b000, 1'b1, 1'b1);
    go(1, 2'b10, 7'h00, 3'b000);
    go(0, 2'b00, 7'h00, 3'b000);

    // reset in the middle of a REM
    go(1, 2'b10, 7'h01, 3'b110);
    go(0, 2'b00, 7'h00, 3'b000);
    do_reset();
    go(0, 2'b00, 7'h00, 3'b000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      go(1'($urandom_range(0, 1)), 2'($urandom), f7, 3'($urandom),
         ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end
    go(0, 2'b00, 7'h00, 3'b000, 1'b1);
    go(0, 2'b00, 7'h00, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised successor to the combinational ALU-control decoder, sitting at the ID/EX boundary. It decodes ALUop/funct_3/funct_7 into an extended operation code covering base RV32I ALU ops, branch compare and the RV32M multiply/divide group. It sequences multi-cycle ops: it starts the M-unit, stalls the pipeline while the op runs, and flags completion. Flush aborts any in-flight op.

## Interface
- OP_W, 5: operation width; must be ≥5; all-ones encodes invalid.
- MUL_LAT, 3: fixed multiplier latency in cycles; must be ≥1.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  ID stage presents an instruction
- flush  in  1  kill current/in-flight op
- ALUop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct_7  in  7  instruction funct7
- funct_3  in  3  instruction funct3
- md_done  in  1  divider completion strobe
- operation  out  OP_W  registered op code, held while busy
- op_valid  out  1  one-cycle strobe: operation/result valid
- illegal  out  1  registered with op_valid: decode was invalid
- md_start  out  1  one-cycle M-unit start pulse
- md_abort  out  1  one-cycle abort pulse on flush while busy
- busy  out  1  stall request to hazard unit

## Operation
- Codes: AND 0, OR 1, ADD 2, XOR 3, SLL 4, SRL 5, SUB 6, SRA 7, SLT 8, SLTU 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 16, REM 17, REMU 18, invalid = all ones.
- ALUop 00 → ADD; 01 → SUB; 11 adds SLTI/SLTIU (funct_3 010/011) to the I-type set, with SRAI when funct_7=0100000; 10 adds SLT/SLTU and funct_7=0000001 M-group (funct_3 000–111 → MUL…REMU).
- Unlisted R-type funct_7/funct_3 combinations decode invalid.
- FSM states: IDLE, MUL_WAIT, DIV_WAIT.
- Accept condition: IDLE & valid_i & !flush. valid_i is ignored when not IDLE.
- Accept of a single-cycle op or an invalid op: stay IDLE; op_valid=1 next cycle; illegal=1 if invalid.
- Accept of a MUL-class op: go to MUL_WAIT, cnt ← MUL_LAT−1, md_start=1 next cycle. Each cycle with cnt≠0, decrement. When cnt=0, go to IDLE and set op_valid.
- Accept of a DIV/REM-class op: go to DIV_WAIT, md_start=1 next cycle. On md_done go to IDLE and set op_valid. md_done is ignored in other states.
- busy = (state≠IDLE), decoded from the state register.
- flush in any state: next cycle IDLE, op_valid=0, md_start=0. md_abort=1 for one cycle if the state was not IDLE.
- flush overrides md_done and cnt expiry in the same cycle.
- Reset values: state IDLE, cnt 0, operation all-ones, op_valid/illegal/md_start/md_abort/busy 0.
- Reset mid-operation drops to IDLE immediately, with no abort pulse.

## Timing
- Accept on the edge ending cycle N.
- Single-cycle op: op_valid in cycle N+1.
- MUL op: md_start in N+1; busy in N+1…N+MUL_LAT; op_valid in N+MUL_LAT+1, with busy low.
- DIV op: md_start in N+1; md_done high in cycle M gives op_valid and busy=0 in M+1. md_done in N+1 is legal.
- Back-to-back single-cycle ops are accepted every cycle, giving a continuous op_valid.
- A new op may be accepted in the same cycle op_valid of a multi-cycle op is high.
- operation holds its value until the next accept.

## Configuration
- RV32M_EN defined: M-group decode, MUL_WAIT/DIV_WAIT, cnt and md_* logic are present.
- RV32M_EN undefined: funct_7=0000001 decodes invalid; FSM stays IDLE; md_start, md_abort and busy are tied 0; md_done is unused; MUL_LAT is ignored.

## Structure
- Package alu_ctrl_pkg holds:
  - op-code localparams;
  - ALUop constants;
  - funct_7 constants (0000000, 0100000, 0000001);
  - state enum typedef;
  - is_mul/is_div classification functions.
- Sub-module alu_op_decode is purely combinational (ALUop/funct → operation, invalid) and is instantiated once.
- FSM, counter and output registers live in the top level.

## Test plan
- Reset asserted mid-DIV_WAIT → next cycle busy=0, operation=31, no md_abort.
- ALUop=10, funct_3=000, funct_7=0100000 accepted → cycle N+1 op_valid=1, operation=6, busy=0.
- MUL (funct_7=0000001, funct_3=000), MUL_LAT=3 → md_start in N+1; busy in N+1..N+3; op_valid, operation=10 in N+4.
- DIVU with md_done in N+5 → busy N+1..N+5, op_valid and operation=16 in N+6; md_done pulsed while IDLE → no effect.
- flush in N+2 of a DIV → md_abort=1 in N+3, busy=0, op_valid=0; a subsequent valid_i is accepted.
- ALUop=10, funct_3=101, funct_7=0000010 → op_valid=1, illegal=1, operation=31; build without RV32M_EN, MUL input → illegal=1, busy never 1.
